// File: rtl/lsu_dmem_master_pkg.sv
// Shared definitions for the load/store data-memory master: RV32I funct3
// encodings, FSM state encoding and the access legality check.
package lsu_dmem_master_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WRITE  = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_t;

    // One flag for any reason the access must not touch memory:
    // bad funct3 for the direction, misaligned H/W, or word index past the end.
    function automatic logic access_err(input logic        we,
                                        input logic [2:0]  f3,
                                        input logic [31:0] addr,
                                        input int unsigned depth);
        logic legal;
        logic misal;
        logic oor;
        case (f3)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_BU, F3_HU:     legal = ~we;
            default:          legal = 1'b0;
        endcase
        misal = (((f3 == F3_H) || (f3 == F3_HU)) && addr[0]) ||
                ((f3 == F3_W) && (addr[1:0] != 2'b00));
        oor   = ({2'b00, addr[31:2]} >= depth);
        return ~legal | misal | oor;
    endfunction

endpackage

// File: rtl/lsu_lane_unit.sv
// Byte/halfword lane handling: extract and extend load data from a memory
// word, and merge sub-word store data into a memory word.
module lsu_lane_unit
    import lsu_dmem_master_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select, load extension and store merge; untouched lanes keep the old word.
    always_comb begin
        byte_sel   = word[{byte_off, 3'b000} +: 8];
        half_sel   = byte_off[1] ? word[31:16] : word[15:0];
        load_data  = word;
        store_data = word;
        case (funct3)
            F3_B:  load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:  load_data = {{16{half_sel[15]}}, half_sel};
            F3_BU: load_data = {24'h0, byte_sel};
            F3_HU: load_data = {16'h0, half_sel};
            default: load_data = word;
        endcase
        case (funct3)
            F3_B: store_data[{byte_off, 3'b000} +: 8] = wdata[7:0];
            F3_H: begin
                if (byte_off[1]) store_data[31:16] = wdata[15:0];
                else             store_data[15:0]  = wdata[15:0];
            end
            F3_W: store_data = wdata;
            default: store_data = word;
        endcase
    end

endmodule

// File: rtl/lsu_dmem_master.sv
// Load/store initiator between the Memory stage and a word-addressed data
// memory with combinational read and synchronous whole-word write.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | ready for a request; latch it on req_valid
//   ST_ACCESS | drive word address, check errors, read/extend or write SW
//   ST_WRITE  | write back the read-modify-write word for SB/SH
//   ST_RESP   | one-cycle response pulse with registered rdata/err
module lsu_dmem_master
    import lsu_dmem_master_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    input  logic [31:0] mem_rd
);

    lsu_state_t  state, state_nxt;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] merged_q;
    logic        err;
    logic        mem_we_raw;
    logic [31:0] load_data;
    logic [31:0] store_data;

    assign err = access_err(we_q, f3_q, addr_q, DEPTH_WORDS);

    lsu_lane_unit u_lane (
        .funct3     (f3_q),
        .byte_off   (addr_q[1:0]),
        .word       (mem_rd),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Request capture and per-access result registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            we_q     <= 1'b0;
            f3_q     <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
            merged_q <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                    end
                end
                ST_ACCESS: begin
                    err_q    <= err;
                    rdata_q  <= (err || we_q) ? 32'h0 : load_data;
                    merged_q <= store_data;
                end
                default: ;
            endcase
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'h0;
        resp_err   = 1'b0;
        mem_a      = 32'h0;
        mem_wd     = 32'h0;
        mem_we_raw = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                mem_a = {addr_q[31:2], 2'b00};
                if (err || !we_q) begin
                    state_nxt = ST_RESP;
                end else if (f3_q == F3_W) begin
                    mem_we_raw = 1'b1;
                    mem_wd     = wdata_q;
                    state_nxt  = ST_RESP;
                end else begin
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                mem_a      = {addr_q[31:2], 2'b00};
                mem_wd     = merged_q;
                mem_we_raw = 1'b1;
                state_nxt  = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_err   = err_q;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Reset is sampled at the same edge the memory would write, so the write
    // strobe is killed as soon as reset_n falls to keep an aborted RMW out of memory.
    assign mem_we = mem_we_raw & reset_n;

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Self-checking bench for lsu_dmem_master: directed cases plus randomized
// loads/stores against a byte-arithmetic reference model of memory.
module tb_lsu_dmem_master;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    logic [31:0] mem     [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    int n_chk = 0;
    int n_fail = 0;
    int we_total = 0;
    int resp_total = 0;
    bit held_prev = 1'b0;
    logic [31:0] got_rdata;

    lsu_dmem_master #(.DEPTH_WORDS(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = ({2'b00, mem_a[31:2]} < 32'(DEPTH)) ? mem[mem_a[7:2]] : 32'hBAD0BAD0;

    always @(posedge clk) begin
        if (mem_we && ({2'b00, mem_a[31:2]} < 32'(DEPTH))) mem[mem_a[7:2]] = mem_wd;
    end

    always @(negedge clk) begin
        if (mem_we)     we_total   <= we_total + 1;
        if (resp_valid) resp_total <= resp_total + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour from the RV32I rules, using shifts and masks on the model memory.
    function automatic void model(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                                  input bit [31:0] wd, output bit err, output bit [31:0] rdata,
                                  output int lat, output int nwe, output bit [31:0] newword);
        bit [31:0] wi;
        int        off;
        bit [31:0] word;
        bit [31:0] b;
        bit [31:0] h;
        bit [31:0] mask;
        wi   = addr >> 2;
        off  = int'(addr % 4);
        word = (wi < 32'(DEPTH)) ? ref_mem[wi[5:0]] : 32'h0;
        err  = (f3 == 3) || (f3 >= 6) || (we && (f3 == 4 || f3 == 5)) ||
               ((f3 == 1 || f3 == 5) && (addr % 2 != 0)) ||
               (f3 == 2 && off != 0) || (wi >= 32'(DEPTH));
        rdata = 0; lat = 2; nwe = 0; newword = word;
        if (!err && !we) begin
            b = (word >> (8 * off)) & 32'd255;
            h = (word >> (8 * off)) & 32'd65535;
            case (f3)
                3'd0: rdata = (b >= 128) ? b - 32'd256 : b;
                3'd1: rdata = (h >= 32768) ? h - 32'd65536 : h;
                3'd2: rdata = word;
                3'd4: rdata = b;
                default: rdata = h;
            endcase
        end else if (!err) begin
            nwe = 1;
            if (f3 == 2) begin
                newword = wd;
            end else begin
                mask    = ((f3 == 0) ? 32'd255 : 32'd65535) << (8 * off);
                newword = (word & ~mask) | ((wd << (8 * off)) & mask);
                lat     = 3;
            end
        end
    endfunction

    // Issue one request (called on a negedge) and check its response.
    // With hold=1, req_valid stays high so the next call's request is already pending.
    task automatic run(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                       input bit [31:0] wd, input bit hold);
        bit        eerr;
        bit [31:0] erd;
        int        elat;
        int        enwe;
        bit [31:0] newword;
        int        waited;
        int        lat;
        int        w0;
        model(we, f3, addr, wd, eerr, erd, elat, enwe, newword);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        if (held_prev) chk("b2b_accept_wait", 32'(waited), 32'd1);
        w0 = we_total;
        @(posedge clk);
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
        chk("ready_busy", 32'(req_ready), 32'd0);
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(elat));
        chk("rdata", resp_rdata, erd);
        chk("err", 32'(resp_err), 32'(eerr));
        chk("we_pulses", 32'(we_total - w0), 32'(enwe));
        got_rdata = resp_rdata;
        if (enwe != 0) ref_mem[addr[7:2]] = newword;
        held_prev = hold;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, limit %0d ns", 500000);
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int r0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wd", mem_wd, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Store/load word and sub-word read-modify-write.
        run(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
        run(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
        chk("lw_after_sw", got_rdata, 32'hDEADBEEF);
        run(1'b1, 3'b010, 32'h10, 32'h11223344, 1'b0);
        run(1'b1, 3'b000, 32'h12, 32'h000000AB, 1'b0);
        chk("sb_rmw_mem", mem[4], 32'h11AB3344);

        // Sign/zero extension.
        run(1'b1, 3'b010, 32'h20, 32'h8081F0F7, 1'b0);
        run(1'b0, 3'b000, 32'h20, 32'h0, 1'b0);
        chk("lb", got_rdata, 32'hFFFFFFF7);
        run(1'b0, 3'b100, 32'h21, 32'h0, 1'b0);
        chk("lbu", got_rdata, 32'h000000F0);
        run(1'b0, 3'b001, 32'h22, 32'h0, 1'b0);
        chk("lh", got_rdata, 32'hFFFF8081);
        run(1'b0, 3'b101, 32'h22, 32'h0, 1'b0);
        chk("lhu", got_rdata, 32'h00008081);

        // Error cases.
        run(1'b0, 3'b010, 32'h22, 32'h0, 1'b0);
        run(1'b1, 3'b001, 32'h13, 32'h5555, 1'b0);
        run(1'b0, 3'b011, 32'h10, 32'h0, 1'b0);
        run(1'b0, 3'b010, 32'h100, 32'h0, 1'b0);
        chk("err_mem_unchanged", mem[4], 32'h11AB3344);

        // Back-to-back with req_valid held: second accepted only after the response.
        run(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
        chk("b2b_first", got_rdata, 32'h11AB3344);
        run(1'b0, 3'b010, 32'h20, 32'h0, 1'b0);
        chk("b2b_second", got_rdata, 32'h8081F0F7);

        // Reset during the WRITE cycle of an SB aborts it.
        @(negedge clk);
        w0 = we_total;
        r0 = resp_total;
        req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h41; req_wdata = 32'h000000CC;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_write_mem_we", 32'(mem_we), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready_after", 32'(req_ready), 32'd1);
        repeat (4) @(negedge clk);
        chk("rst_no_we", 32'(we_total - w0), 32'd0);
        chk("rst_no_resp", 32'(resp_total - r0), 32'd0);
        chk("rst_mem_unchanged", mem[16], ref_mem[16]);
        held_prev = 1'b0;

        // Randomized mix, occasionally back-to-back and out of range.
        for (int n = 0; n < 200; n++) begin
            bit [31:0] a;
            if ($urandom_range(0, 9) == 0) a = $urandom_range(256, 1023);
            else                           a = $urandom_range(0, 255);
            run(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                (n != 199) && ($urandom_range(0, 3) == 0));
        end
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < DEPTH; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
